// File: rtl/bdd_eval_harness.sv
// Self-checking evaluation harness: drives LFSR or exhaustive stimulus into a
// function block, compares against a golden model and tallies mismatches.
module bdd_eval_harness #(
    parameter int unsigned N_TESTS = 100000,
    parameter logic [11:0] SEED    = 12'hACE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic        pause,
    output logic [11:0] vec_o,
    input  logic [8:0]  fn_i,
    input  logic [8:0]  gold_i,
    output logic        busy,
    output logic        done,
    output logic [16:0] test_cnt,
    output logic [16:0] err_cnt,
    output logic [11:0] first_err_vec,
    output logic        first_err_vld
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [11:0] SEED_EFF  = (SEED == 12'h000) ? 12'h001 : SEED;
    localparam logic [16:0] LAST_TEST = 17'(N_TESTS);

    state_t      state;
    logic        mode_q;
    logic        mismatch;
    logic [11:0] vec_next;
    logic [16:0] test_next;

    always_comb begin
        mismatch  = (fn_i != gold_i);
        test_next = test_cnt + 17'd1;
        if (mode_q) begin
            vec_next = vec_o + 12'd1;
        end else begin
            vec_next = {vec_o[10:0], vec_o[11] ^ vec_o[5] ^ vec_o[3] ^ vec_o[0]};
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            vec_o         <= '0;
            test_cnt      <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        mode_q        <= mode;
                        vec_o         <= mode ? 12'h000 : SEED_EFF;
                        test_cnt      <= '0;
                        err_cnt       <= '0;
                        first_err_vec <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                RUN: begin
                    // The result for the current vec_o is counted on the edge that replaces it.
                    if (!pause) begin
                        test_cnt <= test_next;
                        vec_o    <= vec_next;
                        if (mismatch) begin
                            err_cnt <= err_cnt + 17'd1;
                            if (!first_err_vld) begin
                                first_err_vec <= vec_o;
                                first_err_vld <= 1'b1;
                            end
                        end
                        if (test_next == LAST_TEST) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_eval_harness.sv
// Directed bench for bdd_eval_harness: several parameterisations share one clock
// and reset; table-driven per-edge expectations plus hand-written corner sequences.
module tb_bdd_eval_harness;

    typedef struct {
        logic        start;
        logic        pause;
        logic [11:0] vec;
        logic [16:0] cnt;
        logic [16:0] err;
        logic        busy;
        logic        done;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start [4];
    logic        mode  [4];
    logic        pause [4];
    logic [11:0] vec   [4];
    logic [8:0]  fn    [4];
    logic [8:0]  gold  [4];
    logic        busy  [4];
    logic        done  [4];
    logic [16:0] tcnt  [4];
    logic [16:0] ecnt  [4];
    logic [11:0] fev   [4];
    logic        fvld  [4];

    int checks = 0;
    int errors = 0;

    row_t tab_a [9];
    row_t tab_d [16];

    always #5 clk = ~clk;

    // Arbitrary function of the stimulus; instance 2 has one planted mismatch at 0A5.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fn[i]   = vec[i][8:0] ^ {vec[i][11:9], 6'h2A};
            gold[i] = fn[i];
        end
        gold[2] = fn[2] ^ {8'h00, (vec[2] == 12'h0A5)};
    end

    bdd_eval_harness #(.N_TESTS(3), .SEED(12'h001)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .pause(pause[0]),
        .vec_o(vec[0]), .fn_i(fn[0]), .gold_i(gold[0]), .busy(busy[0]), .done(done[0]),
        .test_cnt(tcnt[0]), .err_cnt(ecnt[0]), .first_err_vec(fev[0]), .first_err_vld(fvld[0])
    );

    bdd_eval_harness #(.N_TESTS(10), .SEED(12'h001)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .pause(pause[1]),
        .vec_o(vec[1]), .fn_i(fn[1]), .gold_i(gold[1]), .busy(busy[1]), .done(done[1]),
        .test_cnt(tcnt[1]), .err_cnt(ecnt[1]), .first_err_vec(fev[1]), .first_err_vld(fvld[1])
    );

    bdd_eval_harness #(.N_TESTS(4096), .SEED(12'hACE)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]), .pause(pause[2]),
        .vec_o(vec[2]), .fn_i(fn[2]), .gold_i(gold[2]), .busy(busy[2]), .done(done[2]),
        .test_cnt(tcnt[2]), .err_cnt(ecnt[2]), .first_err_vec(fev[2]), .first_err_vld(fvld[2])
    );

    bdd_eval_harness #(.N_TESTS(4095), .SEED(12'h000)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode[3]), .pause(pause[3]),
        .vec_o(vec[3]), .fn_i(fn[3]), .gold_i(gold[3]), .busy(busy[3]), .done(done[3]),
        .test_cnt(tcnt[3]), .err_cnt(ecnt[3]), .first_err_vec(fev[3]), .first_err_vld(fvld[3])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int idx, input row_t r, input int n);
        start[idx] = r.start;
        pause[idx] = r.pause;
        step();
        start[idx] = 1'b0;
        pause[idx] = 1'b0;
        chk($sformatf("inst%0d row%0d vec", idx, n), 32'(vec[idx]), 32'(r.vec));
        chk($sformatf("inst%0d row%0d test_cnt", idx, n), 32'(tcnt[idx]), 32'(r.cnt));
        chk($sformatf("inst%0d row%0d err_cnt", idx, n), 32'(ecnt[idx]), 32'(r.err));
        chk($sformatf("inst%0d row%0d busy", idx, n), 32'(busy[idx]), 32'(r.busy));
        chk($sformatf("inst%0d row%0d done", idx, n), 32'(done[idx]), 32'(r.done));
    endtask

    task automatic chk_all_zero(input int idx, input string tag);
        chk({tag, " vec"}, 32'(vec[idx]), 32'h0);
        chk({tag, " test_cnt"}, 32'(tcnt[idx]), 32'h0);
        chk({tag, " err_cnt"}, 32'(ecnt[idx]), 32'h0);
        chk({tag, " first_err_vec"}, 32'(fev[idx]), 32'h0);
        chk({tag, " first_err_vld"}, 32'(fvld[idx]), 32'h0);
        chk({tag, " busy"}, 32'(busy[idx]), 32'h0);
        chk({tag, " done"}, 32'(done[idx]), 32'h0);
    endtask

    initial begin
        int   edges;
        logic zero_seen;

        // LFSR run of 3 from seed 001, start ignored in RUN, pause inert in DONE, restart from DONE.
        tab_a[0] = '{1'b1, 1'b0, 12'h001, 17'd0, 17'd0, 1'b1, 1'b0};
        tab_a[1] = '{1'b0, 1'b0, 12'h003, 17'd1, 17'd0, 1'b1, 1'b0};
        tab_a[2] = '{1'b1, 1'b0, 12'h007, 17'd2, 17'd0, 1'b1, 1'b0};
        tab_a[3] = '{1'b0, 1'b0, 12'h00F, 17'd3, 17'd0, 1'b0, 1'b1};
        tab_a[4] = '{1'b0, 1'b1, 12'h00F, 17'd3, 17'd0, 1'b0, 1'b1};
        tab_a[5] = '{1'b1, 1'b0, 12'h001, 17'd0, 17'd0, 1'b1, 1'b0};
        tab_a[6] = '{1'b0, 1'b0, 12'h003, 17'd1, 17'd0, 1'b1, 1'b0};
        tab_a[7] = '{1'b0, 1'b0, 12'h007, 17'd2, 17'd0, 1'b1, 1'b0};
        tab_a[8] = '{1'b0, 1'b0, 12'h00F, 17'd3, 17'd0, 1'b0, 1'b1};

        // Counter run of 10 with a 5-cycle pause after 3 vectors: done 5 edges late.
        tab_d[0]  = '{1'b1, 1'b0, 12'h000, 17'd0,  17'd0, 1'b1, 1'b0};
        tab_d[1]  = '{1'b0, 1'b0, 12'h001, 17'd1,  17'd0, 1'b1, 1'b0};
        tab_d[2]  = '{1'b0, 1'b0, 12'h002, 17'd2,  17'd0, 1'b1, 1'b0};
        tab_d[3]  = '{1'b0, 1'b0, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[4]  = '{1'b0, 1'b1, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[5]  = '{1'b0, 1'b1, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[6]  = '{1'b0, 1'b1, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[7]  = '{1'b0, 1'b1, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[8]  = '{1'b0, 1'b1, 12'h003, 17'd3,  17'd0, 1'b1, 1'b0};
        tab_d[9]  = '{1'b0, 1'b0, 12'h004, 17'd4,  17'd0, 1'b1, 1'b0};
        tab_d[10] = '{1'b0, 1'b0, 12'h005, 17'd5,  17'd0, 1'b1, 1'b0};
        tab_d[11] = '{1'b0, 1'b0, 12'h006, 17'd6,  17'd0, 1'b1, 1'b0};
        tab_d[12] = '{1'b0, 1'b0, 12'h007, 17'd7,  17'd0, 1'b1, 1'b0};
        tab_d[13] = '{1'b0, 1'b0, 12'h008, 17'd8,  17'd0, 1'b1, 1'b0};
        tab_d[14] = '{1'b0, 1'b0, 12'h009, 17'd9,  17'd0, 1'b1, 1'b0};
        tab_d[15] = '{1'b0, 1'b0, 12'h00A, 17'd10, 17'd0, 1'b0, 1'b1};

        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            mode[i]  = 1'b0;
            pause[i] = 1'b0;
        end

        #2 rst_n = 1'b0;
        #1 chk_all_zero(0, "reset");
        step();
        rst_n   = 1'b1;
        mode[0] = 1'b0;
        for (int i = 0; i < 9; i++) apply(0, tab_a[i], i);

        mode[1] = 1'b1;
        for (int i = 0; i < 16; i++) apply(1, tab_d[i], i);

        // Exhaustive sweep with one planted mismatch, checking capture and wrap.
        mode[2]  = 1'b1;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        repeat (165) step();
        chk("sweep pre vec", 32'(vec[2]), 32'h0A5);
        chk("sweep pre err_cnt", 32'(ecnt[2]), 32'h0);
        chk("sweep pre first_err_vld", 32'(fvld[2]), 32'h0);
        step();
        chk("sweep post vec", 32'(vec[2]), 32'h0A6);
        chk("sweep post test_cnt", 32'(tcnt[2]), 32'h0A6);
        chk("sweep post err_cnt", 32'(ecnt[2]), 32'h1);
        chk("sweep post first_err_vec", 32'(fev[2]), 32'h0A5);
        chk("sweep post first_err_vld", 32'(fvld[2]), 32'h1);
        edges = 0;
        while (!done[2] && edges < 5000) begin
            step();
            edges++;
        end
        chk("sweep done", 32'(done[2]), 32'h1);
        chk("sweep test_cnt", 32'(tcnt[2]), 32'h1000);
        chk("sweep err_cnt", 32'(ecnt[2]), 32'h1);
        chk("sweep first_err_vec", 32'(fev[2]), 32'h0A5);
        chk("sweep first_err_vld", 32'(fvld[2]), 32'h1);
        chk("sweep wrapped vec", 32'(vec[2]), 32'h000);

        // Zero seed promoted to 001; full LFSR period never visits 000 and returns to 001.
        mode[3]  = 1'b0;
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        chk("seed0 first vec", 32'(vec[3]), 32'h001);
        zero_seen = 1'b0;
        edges = 0;
        while (!done[3] && edges < 5000) begin
            step();
            edges++;
            if (vec[3] == 12'h000) zero_seen = 1'b1;
        end
        chk("seed0 zero seen", 32'(zero_seen), 32'h0);
        chk("seed0 done", 32'(done[3]), 32'h1);
        chk("seed0 test_cnt", 32'(tcnt[3]), 32'd4095);
        chk("seed0 period vec", 32'(vec[3]), 32'h001);

        // Asynchronous reset mid-run, then a fresh LFSR run from seed ACE.
        mode[2]  = 1'b0;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        repeat (50) step();
        chk("midrun test_cnt", 32'(tcnt[2]), 32'd50);
        chk("midrun busy", 32'(busy[2]), 32'h1);
        #3 rst_n = 1'b0;
        #1 chk_all_zero(2, "async reset");
        step();
        chk("held reset busy", 32'(busy[2]), 32'h0);
        rst_n    = 1'b1;
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        chk("rerun vec", 32'(vec[2]), 32'hACE);
        chk("rerun test_cnt", 32'(tcnt[2]), 32'h0);
        chk("rerun busy", 32'(busy[2]), 32'h1);
        step();
        chk("rerun next vec", 32'(vec[2]), 32'h59C);
        chk("rerun next test_cnt", 32'(tcnt[2]), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
